// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access sequencer.
package spi_reg_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CMD      = 3'd1,
      WR_DATA  = 3'd2,
      RD_FETCH = 3'd3,
      RD_LOAD  = 3'd4,
      RD_DATA  = 3'd5
   } state_e;

   localparam int         CMD_RW_BIT      = 7;
   localparam logic [7:0] STATUS_BYTE_DEF = 8'h5A;

endpackage

// File: rtl/spi_sync_2ff.sv
// Two-flop level synchroniser; resets high so a held-off chip select reads as deselected.
module spi_sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command/register sequencer behind spi_slave: first byte {rw,addr}, then write or read stream.
// Define SPI_REG_AUTOINC_EN for burst addressing; otherwise the address is fixed per frame.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int         ADDR_W      = 7,
   parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              spi_ssel,
   input  logic              byte_rx_vld,
   input  logic [7:0]        rx_data,
   input  logic              data_needed,
   output logic [7:0]        tx_data,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              reg_wr_en,
   output logic [7:0]        reg_wr_data,
   output logic              reg_rd_en,
   input  logic [7:0]        reg_rd_data,
   output logic              frame_done,
   output logic [7:0]        byte_cnt,
   output logic [2:0]        dbg_state
);

   logic              ssel_s;
   logic              ssel_prev_q;
   logic              ssel_fall;
   logic              ssel_rise;
   logic              abort;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              wr_en_q, wr_en_d;
   logic              done_q, done_d;
   logic              pend_q, pend_d;

   spi_sync_2ff u_ssel_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (spi_ssel),
      .q     (ssel_s)
   );

   assign ssel_fall = ssel_prev_q & ~ssel_s;
   assign ssel_rise = ~ssel_prev_q & ssel_s;
   assign abort     = (state_q != IDLE) && ssel_rise;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     if (ssel_fall) state_d = CMD;
            CMD:      if (byte_rx_vld) state_d = rx_data[CMD_RW_BIT] ? RD_FETCH : WR_DATA;
            WR_DATA:  state_d = WR_DATA;
            RD_FETCH: state_d = RD_LOAD;
            RD_LOAD:  state_d = RD_DATA;
            RD_DATA:  if (data_needed || pend_q) state_d = RD_FETCH;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Datapath next-state; a data_needed that lands while a fetch is in flight is parked in pend.
   always_comb begin
      addr_d    = addr_q;
      tx_d      = tx_q;
      wr_data_d = wr_data_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
      pend_d    = pend_q;
      if (abort) begin
         tx_d   = STATUS_BYTE;
         done_d = (cnt_q != 8'd0);
         pend_d = 1'b0;
      end else begin
         if ((state_q != IDLE) && byte_rx_vld && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
`ifdef SPI_REG_AUTOINC_EN
         if (wr_en_q) addr_d = addr_q + ADDR_W'(1);
`endif
         case (state_q)
            IDLE: begin
               if (ssel_fall) begin
                  cnt_d  = 8'd0;
                  tx_d   = STATUS_BYTE;
                  pend_d = 1'b0;
               end
            end
            CMD: begin
               if (byte_rx_vld) begin
                  addr_d = rx_data[ADDR_W-1:0];
                  pend_d = data_needed;
               end
            end
            WR_DATA: begin
               if (byte_rx_vld) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = rx_data;
               end
            end
            RD_FETCH: begin
               if (data_needed) pend_d = 1'b1;
            end
            RD_LOAD: begin
               tx_d = reg_rd_data;
               if (data_needed) pend_d = 1'b1;
            end
            RD_DATA: begin
               if (data_needed || pend_q) begin
                  pend_d = 1'b0;
`ifdef SPI_REG_AUTOINC_EN
                  addr_d = addr_q + ADDR_W'(1);
`endif
               end
            end
            default: pend_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ssel_prev_q <= 1'b1;
         addr_q      <= '0;
         tx_q        <= STATUS_BYTE;
         wr_data_q   <= 8'd0;
         cnt_q       <= 8'd0;
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         ssel_prev_q <= ssel_s;
         addr_q      <= addr_d;
         tx_q        <= tx_d;
         wr_data_q   <= wr_data_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         done_q      <= done_d;
         pend_q      <= pend_d;
      end
   end

   always_comb begin
      reg_rd_en   = (state_q == RD_FETCH) && !ssel_rise;
      tx_data     = tx_q;
      reg_addr    = addr_q;
      reg_wr_en   = wr_en_q;
      reg_wr_data = wr_data_q;
      frame_done  = done_q;
      byte_cnt    = cnt_q;
      dbg_state   = state_q;
   end

endmodule
